// File: rtl/req_ack_initiator.sv
// Request/acknowledge initiator: waits a clamped start-to-req gap, raises req until
// an acknowledge (ignored in the first req cycle) or a timeout, then reports the outcome.
module req_ack_initiator #(
  parameter int MIN_GAP = 3,
  parameter int MAX_GAP = 10,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] gap,
  input  logic       ack,
  output logic       req,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] match_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    MIN_G   = 4'(MIN_GAP);
  localparam logic [3:0]    MAX_G   = 4'(MAX_GAP);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GAP, REQ} state_t;

  state_t        state, state_nx;
  logic [3:0]    gap_cnt, gap_cnt_nx;
  logic [TW-1:0] req_cnt, req_cnt_nx;
  logic [3:0]    gap_clamped;
  logic          req_nx, busy_nx, done_nx, timeout_nx;
  logic [7:0]    match_nx;

  assign gap_clamped = (gap < MIN_G) ? MIN_G : ((gap > MAX_G) ? MAX_G : gap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      req_cnt     <= '0;
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      match_cnt   <= '0;
    end else begin
      state       <= state_nx;
      gap_cnt     <= gap_cnt_nx;
      req_cnt     <= req_cnt_nx;
      req         <= req_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      timeout_err <= timeout_nx;
      match_cnt   <= match_nx;
    end
  end

  // gap_cnt is loaded with G-1 so req is registered high at the start of cycle T+G;
  // req_cnt==0 marks the first req cycle, in which ack is deliberately ignored.
  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    req_cnt_nx = req_cnt;
    req_nx     = req;
    busy_nx    = busy;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    match_nx   = match_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = GAP;
          gap_cnt_nx = gap_clamped - 4'd1;
          busy_nx    = 1'b1;
          req_nx     = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_nx   = REQ;
          req_nx     = 1'b1;
          req_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt - 4'd1;
        end
      end
      REQ: begin
        // Acknowledge takes priority over a timeout landing on the same edge.
        if (ack && (req_cnt != '0)) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          if (match_cnt != 8'hFF) match_nx = match_cnt + 8'd1;
        end else if (req_cnt == TO_LAST) begin
          state_nx   = IDLE;
          req_nx     = 1'b0;
          busy_nx    = 1'b0;
          timeout_nx = 1'b1;
        end else begin
          req_cnt_nx = req_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_req_ack_initiator.sv
// Self-checking bench for req_ack_initiator: directed scenarios plus randomized
// traffic compared against a timestamp-based transaction model.
module tb_req_ack_initiator;

  localparam int MIN_GAP = 3;
  localparam int MAX_GAP = 10;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] gap = 4'd0;
  logic       ack = 1'b0;
  logic       req, busy, done, timeout_err;
  logic [7:0] match_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // Model: a transaction is described by its start edge and gap; outcomes follow from edge arithmetic.
  int  edge_no = 0;
  bit  m_active = 0;
  int  m_t0 = 0;
  int  m_g = 0;
  int  m_cnt = 0;
  bit  m_req = 0, m_busy = 0, m_done = 0, m_tmo = 0;

  req_ack_initiator #(.MIN_GAP(MIN_GAP), .MAX_GAP(MAX_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gap(gap), .ack(ack),
    .req(req), .busy(busy), .done(done), .timeout_err(timeout_err), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  function automatic int clampg(int g);
    if (g < MIN_GAP) return MIN_GAP;
    if (g > MAX_GAP) return MAX_GAP;
    return g;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_cnt = 0; m_req = 0; m_busy = 0; m_done = 0; m_tmo = 0;
  endfunction

  // Advance one clock edge, update the model with the sampled inputs, settle 1 time unit.
  task automatic tick();
    int first_edge, last_edge;
    @(posedge clk);
    edge_no++;
    m_done = 0;
    m_tmo  = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_active) begin
      first_edge = m_t0 + m_g;
      last_edge  = m_t0 + m_g + TIMEOUT - 1;
      if (ack && edge_no > first_edge && edge_no <= last_edge) begin
        m_done = 1; m_active = 0;
        if (m_cnt < 255) m_cnt++;
      end else if (edge_no == last_edge) begin
        m_tmo = 1; m_active = 0;
      end
    end else if (start) begin
      m_active = 1; m_t0 = edge_no; m_g = clampg(int'(gap));
    end
    m_busy = m_active;
    m_req  = m_active && (edge_no >= m_t0 + m_g - 1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; gap = 4'd0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({req, busy, done, timeout_err, match_cnt} !== 12'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got req=%b busy=%b done=%b tmo=%b cnt=%0d, want all 0",
               req, busy, done, timeout_err, match_cnt);
    end
    do_reset();
  endtask

  task automatic test_basic_gap5();
    bit exp_req;
    int base;
    do_reset();
    base = match_cnt;
    for (int k = 0; k <= 9; k++) begin
      start = (k == 0); gap = 4'd5; ack = (k == 7);
      tick();
      exp_req = (k >= 4 && k <= 6);
      n_checks++;
      if (req !== exp_req || done !== (k == 7) || busy !== (k <= 6)) begin
        n_fail++;
        $display("[TB] FAIL gap5_edge%0d: got req=%b done=%b busy=%b, want req=%b done=%b busy=%b",
                 k, req, done, busy, exp_req, (k == 7), (k <= 6));
      end
    end
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (match_cnt !== 8'(base + 1)) begin
      n_fail++;
      $display("[TB] FAIL gap5_count: got %0d, want %0d", match_cnt, base + 1);
    end
  endtask

  task automatic test_gap_clamp();
    int lat, exp_lat;
    int gaps[2] = '{0, 15};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      lat = -1;
      exp_lat = clampg(gaps[i]);
      start = 1'b1; gap = 4'(gaps[i]); ack = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        tick();
        if (req === 1'b1) lat = k + 1;
      end
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("[TB] FAIL gap_clamp_%0d: req latency got %0d, want %0d", gaps[i], lat, exp_lat);
      end
      ack = 1'b1; tick(); tick(); ack = 1'b0; tick();
      n_checks++;
      if (match_cnt !== 8'd1 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL gap_clamp_done_%0d: got cnt=%0d busy=%b, want cnt=1 busy=0",
                 gaps[i], match_cnt, busy);
      end
    end
  endtask

  task automatic test_first_cycle_ack();
    int tmo_at = -1, dones = 0, base;
    do_reset();
    base = match_cnt;
    for (int k = 0; k <= 24; k++) begin
      start = (k == 0); gap = 4'd3; ack = (k == 3);
      tick();
      if (timeout_err === 1'b1 && tmo_at < 0) tmo_at = k;
      if (done === 1'b1) dones++;
    end
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (tmo_at !== 3 + TIMEOUT - 1 || dones !== 0) begin
      n_fail++;
      $display("[TB] FAIL first_cycle_ack: timeout at edge %0d dones=%0d, want edge %0d dones=0",
               tmo_at, dones, 3 + TIMEOUT - 1);
    end
    n_checks++;
    if (match_cnt !== 8'(base)) begin
      n_fail++;
      $display("[TB] FAIL first_cycle_cnt: got %0d, want %0d", match_cnt, base);
    end
  endtask

  task automatic test_ack_held();
    int dones = 0, done_at = -1, base;
    bit busy_bad = 0;
    do_reset();
    base = match_cnt;
    for (int k = 0; k <= 12; k++) begin
      start = (k == 0 || k == 2 || k == 4); gap = 4'd4; ack = (k >= 5 && k <= 8);
      tick();
      if (done === 1'b1) begin dones++; done_at = k; end
      if (k >= 5 && busy !== 1'b0) busy_bad = 1;
    end
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (dones !== 1 || done_at !== 5) begin
      n_fail++;
      $display("[TB] FAIL ack_held_done: got %0d pulses at edge %0d, want 1 at edge 5", dones, done_at);
    end
    n_checks++;
    if (busy_bad || match_cnt !== 8'(base + 1)) begin
      n_fail++;
      $display("[TB] FAIL ack_held_state: busy_after=%b cnt=%0d, want busy_after=0 cnt=%0d",
               busy_bad, match_cnt, base + 1);
    end
  endtask

  task automatic test_async_reset();
    bit bad = 0;
    do_reset();
    start = 1'b1; gap = 4'd3; ack = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10 && req !== 1'b1; k++) tick();
    ack = 1'b1; tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({req, busy, done, timeout_err, match_cnt} !== 12'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got req=%b busy=%b done=%b tmo=%b cnt=%0d, want all 0",
               req, busy, done, timeout_err, match_cnt);
    end
    start = 1'b1;
    tick(); tick();
    start = 1'b0; ack = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL async_reset_after: spurious busy/done/timeout_err seen, want none");
    end
  endtask

  task automatic test_random();
    int ack_pct = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) ack_pct = $urandom_range(0, 2) * 25;
      start = ($urandom_range(0, 99) < 30);
      gap   = 4'($urandom_range(0, 15));
      ack   = ($urandom_range(0, 99) < ack_pct);
      tick();
      n_checks++;
      if (req !== m_req || busy !== m_busy || done !== m_done || timeout_err !== m_tmo ||
          match_cnt !== 8'(m_cnt) || (done && timeout_err)) begin
        n_fail++;
        $display("[TB] FAIL random_c%0d: got req=%b busy=%b done=%b tmo=%b cnt=%0d, want req=%b busy=%b done=%b tmo=%b cnt=%0d",
                 c, req, busy, done, timeout_err, match_cnt, m_req, m_busy, m_done, m_tmo, m_cnt);
      end
    end
    start = 1'b0; ack = 1'b0;
  endtask

  task automatic test_saturation();
    int dones = 0;
    do_reset();
    start = 1'b1; gap = 4'd0; ack = 1'b1;
    for (int c = 0; c < 1700 && dones < 300; c++) begin
      tick();
      if (done === 1'b1) begin
        dones++;
        n_checks++;
        if (match_cnt !== 8'(m_cnt) || (dones >= 255 && match_cnt !== 8'd255)) begin
          n_fail++;
          $display("[TB] FAIL saturate_txn%0d: got %0d, want %0d", dones, match_cnt, (dones > 255) ? 255 : dones);
        end
      end
    end
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (dones !== 300 || match_cnt !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL saturate_final: got %0d txns cnt=%0d, want 300 txns cnt=255", dones, match_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_gap5();
    test_gap_clamp();
    test_first_cycle_ack();
    test_ack_held();
    test_async_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_ack_initiator.md
REQ_ACK_INITIATOR -- requirements
Module: req_ack_initiator

Interface
REQ-001 Parameter MIN_GAP, default 3: minimum start-to-req delay in cycles.
REQ-002 Parameter MAX_GAP, default 10: maximum start-to-req delay in cycles.
REQ-003 Parameter TIMEOUT, default 16: maximum req-high cycles allowed without ack.
REQ-004 Port clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port start  input  1  request to begin one transaction.
REQ-007 Port gap  input  4  requested start-to-req delay, sampled with start.
REQ-008 Port ack  input  1  responder acknowledge.
REQ-009 Port req  output  1  request to responder; registered.
REQ-010 Port busy  output  1  high while a transaction is in progress.
REQ-011 Port done  output  1  one-cycle pulse when a transaction completes on ack.
REQ-012 Port timeout_err  output  1  one-cycle pulse when a transaction aborts on timeout.
REQ-013 Port match_cnt  output  8  count of ack-completed transactions; saturating.

Function
REQ-014 FSM states SHALL be IDLE, GAP and REQ; all outputs SHALL be registered.
REQ-015 IDLE: req=0, busy=0; start=1 at edge T loads G = clamp(gap, MIN_GAP, MAX_GAP); state goes to GAP.
REQ-016 GAP: busy=1, req=0; a down-counter SHALL make req first high in cycle T+G, so that start ##[MIN_GAP:MAX_GAP] req holds.
REQ-017 REQ: req=1 and busy=1, held continuously until ack is accepted or timeout occurs.
REQ-018 ack SHALL be ignored in the first req-high cycle (T+G); only ack sampled at T+G+1 or later is accepted, so that req ##[1:$] ack holds.
REQ-019 Only the first accepted ack completes the transaction (first_match semantics); later acks SHALL have no effect.
REQ-020 On accepted ack at edge A: in cycle A+1, req=0, busy=0, done=1 for exactly one cycle, match_cnt incremented, state IDLE.
REQ-021 match_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-022 If req has been high TIMEOUT cycles with no accepted ack: next cycle req=0, busy=0, timeout_err=1 for one cycle, match_cnt unchanged, state IDLE.
REQ-023 If ack is accepted on the same edge that the timeout would fire, ack SHALL win: done=1 and timeout_err=0.
REQ-024 start while busy=1 SHALL be ignored and not queued.
REQ-025 start in the cycle where done or timeout_err is high (busy=0) SHALL be accepted normally.
REQ-026 ack in IDLE or GAP SHALL be ignored.
REQ-027 gap<MIN_GAP SHALL use MIN_GAP; gap>MAX_GAP SHALL use MAX_GAP.
REQ-028 done and timeout_err SHALL never be high in the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force req=0, busy=0, done=0, timeout_err=0, match_cnt=0, state IDLE, independent of clk.
REQ-030 Reset mid-transaction SHALL abort it with no done or timeout_err pulse.
REQ-031 After rst_n rises, the first start accepted SHALL be one sampled on a clk edge where rst_n=1.

Verification
REQ-032 start=1, gap=5 at edge 0; ack=1 at edge 7 -> req high cycles 5-7, done=1 and req=0 in cycle 8, match_cnt=1.
REQ-033 gap=0 -> req first high 3 cycles after start; gap=15 -> req first high 10 cycles after start.
REQ-034 ack high in the first req cycle and low afterwards, with none later -> ack ignored, timeout_err pulse after 16 req-high cycles, match_cnt unchanged.
REQ-035 ack held high for 4 cycles starting at the second req cycle -> exactly one done pulse, match_cnt +1; start pulses during GAP and REQ are ignored.
REQ-036 rst_n low during REQ state -> req=0 asynchronously, no done or timeout_err pulse, match_cnt=0.
REQ-037 300 back-to-back acked transactions -> match_cnt=255 after the 255th transaction and stays 255.
